// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_ERR
  } mem_st_e;

endpackage

// File: rtl/pipe_ctrl_unit_fwd_select.sv
// Operand bypass selector for one EX source register: MEM result beats WB data,
// and x0 or non-writing producers never forward.
module fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output fwd_sel_e          sel
);

  // Priority compare of the source against the two in-flight writers.
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Hazard/stall/flush controller for the 5-stage RV32I pipeline: forwarding,
// load-use interlock, redirect flush and a data-memory wait FSM with watchdog.
// Optional feature macro: PIPE_PERF_CNT_EN (stall/flush performance counters).
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned MEM_TMO = 200,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mem_tmo_err,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  mem_st_e            state_q;
  logic [TMO_W-1:0]   timer_q;
  fwd_sel_e           sel_a;
  fwd_sel_e           sel_b;
  logic               mem_stall;
  logic               load_use;
  logic               lu_stall;
  logic               redirect_apply;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src          (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src          (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (sel_b)
  );

  // Hazard detection; memory stall dominates, then redirect, then load-use.
  always_comb begin
    mem_stall      = ((state_q == MS_IDLE) && mem_req && !mem_ack)
                   || (state_q == MS_WAIT) || (state_q == MS_ERR);
    load_use       = ex_memread && (ex_rd != '0)
                   && ((id_use_rs1 && (ex_rd == id_rs1))
                    || (id_use_rs2 && (ex_rd == id_rs2)));
    redirect_apply = ex_redirect && !mem_stall;
    lu_stall       = load_use && !ex_redirect && !mem_stall;
  end

  // Stage enable / flush strobes and forwarding selects.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    fwd_a_sel    = sel_a;
    fwd_b_sel    = sel_b;
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      fwd_a_sel    = FWD_RF;
      fwd_b_sel    = FWD_RF;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (redirect_apply) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (lu_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  // Data-memory wait FSM with timeout watchdog; ERR is left only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MS_IDLE;
      timer_q     <= '0;
      mem_tmo_err <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (mem_req && !mem_ack) begin
            state_q <= MS_WAIT;
            timer_q <= TMO_W'(1);
          end
        end
        MS_WAIT: begin
          if (mem_ack) begin
            state_q <= MS_IDLE;
            timer_q <= '0;
          end else if (timer_q == TMO_W'(MEM_TMO)) begin
            state_q     <= MS_ERR;
            mem_tmo_err <= 1'b1;
          end else begin
            timer_q <= timer_q + TMO_W'(1);
          end
        end
        MS_ERR: begin
          mem_tmo_err <= 1'b1;
        end
        default: begin
          state_q <= MS_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  // Saturating counts of stalled cycles and applied redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((mem_stall || lu_stall) && (stall_q != '1))
        stall_q <= stall_q + PERF_W'(1);
      if (redirect_apply && (flush_q != '1))
        flush_q <= flush_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: stimulus pushes hand-computed expected
// strobes per cycle, a negedge monitor pops and compares.
module tb_pipe_ctrl_unit;
  import pipe_ctrl_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned PW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
  logic          mem_regwrite, wb_regwrite, mem_req, mem_ack;
  logic          pc_en, ifid_en, idex_en, exmem_en;
  logic          ifid_flush, idex_flush, memwb_bubble, mem_tmo_err;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [PW-1:0] stall_cnt, flush_cnt;

  pipe_ctrl_unit #(.REG_AW(AW), .TMO_W(8), .MEM_TMO(4), .PERF_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_redirect  (ex_redirect),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_bubble (memwb_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .mem_tmo_err  (mem_tmo_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct {
    string         name;
    logic [11:0]   outv;
    bit            cc;
    logic [PW-1:0] s;
    logic [PW-1:0] f;
  } exp_t;

  exp_t          q[$];
  exp_t          mx;
  logic [11:0]   act;
  int unsigned   n_chk = 0;
  int unsigned   n_fail = 0;
  bit            cc_en = 1'b0;
  logic [PW-1:0] cc_s = '0;
  logic [PW-1:0] cc_f = '0;

  // {pc,ifid,idex,exmem}, {ifid_flush,idex_flush}, bubble, fwd_a, fwd_b, err
  function automatic logic [11:0] ov(input logic [3:0] en, input logic [1:0] fl,
                                     input logic bub, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic err);
    return {en, fl, bub, fa, fb, err};
  endfunction

  function automatic logic [PW-1:0] cexp(input int unsigned v);
`ifdef PIPE_PERF_CNT_EN
    return PW'(v);
`else
    return (v == 0) ? '0 : '0;
`endif
  endfunction

  logic [11:0] RST, RST_E, NORM, MST, MST_E, REDIR, LU;

  task automatic cnt(input int unsigned s, input int unsigned f);
    cc_en = 1'b1;
    cc_s  = cexp(s);
    cc_f  = cexp(f);
  endtask

  task automatic cyc(input string nm, input logic [11:0] e);
    exp_t x;
    x.name = nm;
    x.outv = e;
    x.cc   = cc_en;
    x.s    = cc_s;
    x.f    = cc_f;
    cc_en  = 1'b0;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // Monitor: one expected entry per sampled cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx  = q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
             memwb_bubble, fwd_a_sel, fwd_b_sel, mem_tmo_err};
      n_chk++;
      if (act !== mx.outv) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", mx.name, act, mx.outv);
      end
      if (mx.cc) begin
        n_chk++;
        if (stall_cnt !== mx.s || flush_cnt !== mx.f) begin
          n_fail++;
          $display("FAIL %s_cnt: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                   mx.name, stall_cnt, flush_cnt, mx.s, mx.f);
        end
      end
    end
  end

  initial begin
    RST   = ov(4'b0000, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0);
    RST_E = ov(4'b0000, 2'b11, 1'b1, 2'b00, 2'b00, 1'b1);
    NORM  = ov(4'b1111, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    MST   = ov(4'b0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0);
    MST_E = ov(4'b0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1);
    REDIR = ov(4'b1111, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
    LU    = ov(4'b0011, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0);

    clr();
    reset = 1'b1;
    @(posedge clk); #1;
    // Reset overrides forwarding even with a matching writer present
    mem_rd = 5; mem_regwrite = 1'b1; ex_rs1 = 5;
    cnt(0, 0);
    cyc("reset", RST);
    reset = 1'b0;
    clr();

    // Forwarding
    mem_rd = 5; mem_regwrite = 1'b1; wb_rd = 5; wb_regwrite = 1'b1;
    ex_rs1 = 5; ex_rs2 = 3;
    cyc("fwd_mem_pri", ov(4'b1111, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0));
    mem_regwrite = 1'b0;
    cyc("fwd_wb", ov(4'b1111, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0));
    ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 1'b1;
    cyc("fwd_x0", NORM);
    ex_rs1 = 4; wb_rd = 4; ex_rs2 = 9; mem_rd = 9;
    cyc("fwd_b_mem", ov(4'b1111, 2'b00, 1'b0, 2'b01, 2'b10, 1'b0));
    clr();

    reset = 1'b1;
    cyc("reset2", RST);
    reset = 1'b0;

    // Load-use interlock
    ex_memread = 1'b1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1'b1;
    cyc("load_use", LU);
    ex_memread = 1'b0; ex_rd = 0; mem_rd = 7; mem_regwrite = 1'b1;
    cyc("load_use_release", NORM);
    clr();
    ex_memread = 1'b1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1'b0;
    cyc("load_use_unread", NORM);
    ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1'b1;
    cyc("load_use_x0", NORM);
    clr();

    // Memory wait, ack on third stalled cycle
    mem_req = 1'b1;
    cyc("mwait0", MST);
    cyc("mwait1", MST);
    mem_ack = 1'b1;
    cyc("mwait_ack", MST);
    mem_req = 1'b0; mem_ack = 1'b0;
    cnt(4, 0);
    cyc("mrelease", NORM);
    mem_req = 1'b1; mem_ack = 1'b1;
    cyc("zero_wait", NORM);
    mem_req = 1'b0;
    cyc("stray_ack", NORM);
    mem_ack = 1'b0;
    cyc("after_stray", NORM);
    mem_req = 1'b1;
    cyc("post_stray_req", MST);
    mem_ack = 1'b1;
    cyc("post_stray_ack", MST);
    mem_req = 1'b0; mem_ack = 1'b0;
    cyc("post_stray_rel", NORM);

    // Redirect beats load-use
    ex_memread = 1'b1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1'b1; ex_redirect = 1'b1;
    cnt(6, 0);
    cyc("redir_over_lu", REDIR);
    clr();
    cnt(6, 1);
    cyc("after_redir", NORM);

    // Redirect held through a memory wait is applied on the release cycle
    mem_req = 1'b1; ex_redirect = 1'b1;
    cyc("hold_w0", MST);
    cyc("hold_w1", MST);
    mem_ack = 1'b1;
    cyc("hold_ack", MST);
    mem_req = 1'b0; mem_ack = 1'b0;
    cyc("redir_release", REDIR);
    ex_redirect = 1'b0;
    cnt(9, 2);
    cyc("after_release", NORM);

    // Reset pulse mid-WAIT
    mem_req = 1'b1;
    cyc("rw0", MST);
    cyc("rw1", MST);
    reset = 1'b1;
    cyc("rw_reset", RST);
    reset = 1'b0; mem_req = 1'b0;
    cnt(0, 0);
    cyc("rw_idle", NORM);

    // Watchdog timeout, MEM_TMO=4
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc($sformatf("tmo_wait%0d", i), MST);
    cyc("tmo_err", MST_E);
    mem_req = 1'b0;
    cyc("err_sticky", MST_E);
    mem_ack = 1'b1;
    cyc("err_ack_ignored", MST_E);
    mem_ack = 1'b0; reset = 1'b1;
    cyc("err_reset", RST_E);
    reset = 1'b0;
    cyc("err_cleared", NORM);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
